stack_core: RTL



---
 rtl/stack_core.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_core.sv
`default_nettype none
// ============================================================================
// Module      : stack_core
// Description : Multicycle stack-machine core (FSM, PC, IR, LIFO, ALU) with a
//               single synchronous memory port, run gating and sticky traps.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_rd,
  output logic                       mem_wr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [2:0]                 opcode,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic [DATA_W-1:0]          tos,
  output logic                       halted,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       retire
);

  localparam int c_depthW = $clog2(DEPTH + 1);
  localparam int c_idxW   = $clog2(DEPTH);

  localparam logic [2:0] c_opPush = 3'd0;
  localparam logic [2:0] c_opPop  = 3'd1;
  localparam logic [2:0] c_opAdd  = 3'd2;
  localparam logic [2:0] c_opSub  = 3'd3;
  localparam logic [2:0] c_opAnd  = 3'd4;
  localparam logic [2:0] c_opNot  = 3'd5;
  localparam logic [2:0] c_opJmp  = 3'd6;
  localparam logic [2:0] c_opJz   = 3'd7;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_pc;
  logic [DATA_W-1:0]     r_ir;
  logic [c_depthW-1:0]   r_depth;
  logic [DATA_W-1:0]     r_stack [DEPTH];
  logic                  r_halted;
  logic                  r_errOvf;
  logic                  r_errUnf;

  logic [2:0]            w_opcode;
  logic [ADDR_W-1:0]     w_irAddr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_lessTwo;
  logic [c_idxW-1:0]     w_topIdx;
  logic [c_idxW-1:0]     w_nosIdx;
  logic [c_idxW-1:0]     w_pushIdx;
  logic [DATA_W-1:0]     w_tos;
  logic [DATA_W-1:0]     w_nos;
  logic                  w_isAlu;
  logic                  w_needOne;
  logic                  w_ovfTrap;
  logic                  w_unfTrap;
  logic                  w_trap;
  logic                  w_commit;
  logic [DATA_W-1:0]     w_alu;

  assign w_opcode  = r_ir[ADDR_W+2:ADDR_W];
  assign w_irAddr  = r_ir[ADDR_W-1:0];

  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == c_depthW'(DEPTH));
  assign w_lessTwo = (r_depth < c_depthW'(2));

  // Slot indices are only meaningful when the trap checks have passed.
  assign w_topIdx  = c_idxW'(r_depth - c_depthW'(1));
  assign w_nosIdx  = c_idxW'(r_depth - c_depthW'(2));
  assign w_pushIdx = c_idxW'(r_depth);

  assign w_tos     = r_stack[w_topIdx];
  assign w_nos     = r_stack[w_nosIdx];

  assign w_isAlu   = (w_opcode == c_opAdd) || (w_opcode == c_opSub) ||
                     (w_opcode == c_opAnd);
  assign w_needOne = (w_opcode == c_opPop) || (w_opcode == c_opNot) ||
                     (w_opcode == c_opJz);

  assign w_ovfTrap = (w_opcode == c_opPush) && w_full;
  assign w_unfTrap = (w_isAlu && w_lessTwo) || (w_needOne && w_empty);
  assign w_trap    = w_ovfTrap || w_unfTrap;
  assign w_commit  = (r_state == EXEC) && !w_trap;

  always_comb begin
    w_alu = w_nos;
    case (w_opcode)
      c_opAdd: w_alu = w_nos + w_tos;
      c_opSub: w_alu = w_nos - w_tos;
      c_opAnd: w_alu = w_nos & w_tos;
      default: w_alu = w_nos;
    endcase
  end

  // Memory strobes decode the current state so each access lands on the edge
  // that ends it; the fetch strobe is also held off while reset is applied.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = r_pc;
    mem_wdata = w_tos;
    retire    = 1'b0;
    case (r_state)
      FETCH: begin
        mem_rd = run && !rst;
      end
      EXEC: begin
        if (!w_trap) begin
          if (w_opcode == c_opPush) begin
            mem_rd   = 1'b1;
            mem_addr = w_irAddr;
          end else begin
            retire = 1'b1;
            if (w_opcode == c_opPop) begin
              mem_wr   = 1'b1;
              mem_addr = w_irAddr;
            end
          end
        end
      end
      WB: begin
        retire = 1'b1;
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_depth  <= '0;
      r_halted <= 1'b0;
      r_errOvf <= 1'b0;
      r_errUnf <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (run) begin
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= EXEC;
        end
        EXEC: begin
          if (w_trap) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
            r_errOvf <= r_errOvf || w_ovfTrap;
            r_errUnf <= r_errUnf || w_unfTrap;
          end else begin
            r_state <= FETCH;
            case (w_opcode)
              c_opPush: r_state <= WB;
              c_opPop, c_opAdd, c_opSub, c_opAnd:
                r_depth <= r_depth - c_depthW'(1);
              c_opJmp: r_pc <= w_irAddr;
              c_opJz: begin
                if (w_tos == '0) begin
                  r_pc <= w_irAddr;
                end
              end
              default: r_state <= FETCH;
            endcase
          end
        end
        WB: begin
          r_depth <= r_depth + c_depthW'(1);
          r_state <= FETCH;
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // Stack contents carry no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_commit && w_isAlu) begin
      r_stack[w_nosIdx] <= w_alu;
    end
    if (w_commit && (w_opcode == c_opNot)) begin
      r_stack[w_topIdx] <= ~w_tos;
    end
    if (r_state == WB) begin
      r_stack[w_pushIdx] <= mem_rdata;
    end
  end

  assign opcode  = w_opcode;
  assign pc      = r_pc;
  assign depth   = r_depth;
  assign tos     = w_empty ? '0 : w_tos;
  assign halted  = r_halted;
  assign err_ovf = r_errOvf;
  assign err_unf = r_errUnf;

endmodule
`default_nettype wire
